// File: rtl/output_latch.sv
// output_latch: holds the newest and previous CPU output values for the seven-segment block,
// with a post-write flash on dp1 and a halt blink on dp2.
module output_latch #(
    parameter int FLASH_LEN = 12_500_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        out_we,
    input  logic [15:0] out_data,
    input  logic        out_clr,
    input  logic        halt,
    output logic [15:0] disp1,
    output logic [15:0] disp2,
    output logic        dp1,
    output logic        dp2
);
    localparam int FW = $clog2(FLASH_LEN + 1);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic {OFF = 1'b0, ON = 1'b1} phase_t;

    logic [FW-1:0] flash_cnt;
    logic [BW-1:0] blink_cnt, blink_nxt;
    phase_t        phase, phase_nxt;
    logic          halt_r;

    // a same-cycle clear zeroes the old value before the write shifts it down
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp1     <= '0;
            disp2     <= '0;
            flash_cnt <= '0;
            halt_r    <= 1'b0;
        end else begin
            if (out_we) begin
                disp1 <= out_data;
                disp2 <= out_clr ? '0 : disp1;
            end else if (out_clr) begin
                disp1 <= '0;
                disp2 <= '0;
            end
            flash_cnt <= out_we ? FW'(FLASH_LEN) : out_clr ? '0 : flash_cnt - FW'(flash_cnt != '0);
            halt_r    <= halt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= ON;
        end else begin
            blink_cnt <= blink_nxt;
            phase     <= phase_nxt;
        end
    end

    always_comb begin
        blink_nxt = '0;
        phase_nxt = ON;
        if (halt_r) begin
            blink_nxt = (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
            phase_nxt = (blink_cnt == BW'(BLINK_DIV - 1)) ? ((phase == ON) ? OFF : ON) : phase;
        end
    end

    assign dp1 = (flash_cnt != '0);
    assign dp2 = halt_r & (phase == ON);
endmodule

// File: tb/tb_output_latch.sv
// tb_output_latch: scoreboard bench for output_latch with FLASH_LEN=4, BLINK_DIV=3.
module tb_output_latch;
    logic        clock = 1'b0, reset = 1'b1, out_we = 1'b0, out_clr = 1'b0, halt = 1'b0;
    logic [15:0] out_data = '0;
    logic [15:0] disp1, disp2;
    logic        dp1, dp2;

    output_latch #(.FLASH_LEN(4), .BLINK_DIV(3)) dut (
        .clock(clock), .reset(reset), .out_we(out_we), .out_data(out_data), .out_clr(out_clr),
        .halt(halt), .disp1(disp1), .disp2(disp2), .dp1(dp1), .dp2(dp2)
    );

    always #5 clock = ~clock;

    typedef struct {logic [15:0] d1, d2; logic p1, p2;} exp_t;
    exp_t        sb[$];
    int          n_vec = 0, n_err = 0, hi1 = 0;
    logic [15:0] m_d1, m_d2;
    int          m_fc, m_bc;
    logic        m_hr, m_ph;
    logic [13:0] pat;
    logic [3:0]  pat4;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mreset;
        m_d1 = '0; m_d2 = '0; m_fc = 0; m_bc = 0; m_hr = 1'b0; m_ph = 1'b1;
        sb.delete();
    endtask

    task automatic cyc(input logic we, input logic [15:0] data, input logic clr, input logic h, input string tag);
        exp_t e;
        out_we = we; out_data = data; out_clr = clr; halt = h;
        if (clr) begin m_d1 = '0; m_d2 = '0; end
        if (we) begin m_d2 = m_d1; m_d1 = data; end
        m_fc = we ? 4 : clr ? 0 : (m_fc > 0 ? m_fc - 1 : 0);
        if (!m_hr) begin m_bc = 0; m_ph = 1'b1; end
        else if (m_bc == 2) begin m_bc = 0; m_ph = !m_ph; end
        else m_bc++;
        m_hr = h;
        e = '{m_d1, m_d2, m_fc != 0, m_hr & m_ph};
        sb.push_back(e);
        @(posedge clock); #1;
        e = sb.pop_front();
        check({tag, ".disp1"}, disp1, e.d1);
        check({tag, ".disp2"}, disp2, e.d2);
        check({tag, ".dp1"}, 16'(dp1), 16'(e.p1));
        check({tag, ".dp2"}, 16'(dp2), 16'(e.p2));
        hi1 += int'(dp1);
    endtask

    initial begin
        mreset();
        repeat (2) @(posedge clock);
        #1;
        check("rst.disp1", disp1, 16'h0000);
        check("rst.disp2", disp2, 16'h0000);
        check("rst.dp", {14'b0, dp1, dp2}, 16'h0000);
        @(negedge clock) reset = 1'b0;
        repeat (5) cyc(0, 16'h0, 0, 0, "idle");

        hi1 = 0;
        cyc(1, 16'h1234, 0, 0, "wrA");
        cyc(1, 16'hABCD, 0, 0, "wrB");
        check("b2b.disp1", disp1, 16'hABCD);
        check("b2b.disp2", disp2, 16'h1234);
        repeat (6) cyc(0, 16'h0, 0, 0, "b2b_idle");
        check("b2b.flash_len", 16'(hi1), 16'd5);

        hi1 = 0;
        cyc(1, 16'h00FF, 0, 0, "rtA");
        cyc(0, 16'h0, 0, 0, "rt_gap");
        cyc(1, 16'h0F0F, 0, 0, "rtB");
        repeat (6) cyc(0, 16'h0, 0, 0, "rt_idle");
        check("retrig.flash_len", 16'(hi1), 16'd6);

        cyc(1, 16'h1111, 0, 0, "pre_clr");
        repeat (5) cyc(0, 16'h0, 0, 0, "pre_idle");
        cyc(1, 16'h5555, 1, 0, "clr_wr");
        check("clrwr.disp1", disp1, 16'h5555);
        check("clrwr.disp2", disp2, 16'h0000);
        check("clrwr.dp1", 16'(dp1), 16'h0001);
        cyc(0, 16'h0, 1, 0, "clr");
        check("clr.disp1", disp1, 16'h0000);
        cyc(0, 16'h0, 0, 0, "post_clr");

        for (int i = 0; i < 14; i++) begin
            cyc(0, 16'h0, 0, 1, "halt");
            pat[13 - i] = dp2;
        end
        check("halt.pattern", 16'(pat), 16'(14'b11100011100011));
        cyc(1, 16'h7777, 0, 0, "unhalt");
        check("unhalt.dp2", 16'(dp2), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 16'h0, 0, 1, "rehalt");
            pat4[3 - i] = dp2;
        end
        check("rehalt.pattern", 16'(pat4), 16'(4'b1110));

        cyc(1, 16'h2468, 0, 1, "mid");
        #3 reset = 1'b1;
        #1;
        check("arst.disp1", disp1, 16'h0000);
        check("arst.disp2", disp2, 16'h0000);
        check("arst.dp", {14'b0, dp1, dp2}, 16'h0000);
        mreset();
        out_we = 1'b0; halt = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        hi1 = 0;
        cyc(1, 16'h1234, 0, 0, "rwA");
        cyc(1, 16'hABCD, 0, 0, "rwB");
        check("rst_b2b.disp2", disp2, 16'h1234);
        repeat (6) cyc(0, 16'h0, 0, 0, "rw_idle");
        check("rst_b2b.flash_len", 16'(hi1), 16'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
